// File: rtl/tt_uart_rx.sv
// rtl/tt_uart_rx.sv - UART receiver with receive FIFO; 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module tt_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          LW       = AW + 1;
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  state_t      state, state_next;
  logic [15:0] timer, timer_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  shift, shift_next;
  logic        frame_err_next;
  logic        push;
  logic        tick;
`ifdef UART_RX_PARITY_EN
  logic        bad_par, bad_par_next;
`endif

  // Timer counts down; the sample point is the cycle it reads 1, so reloading
  // FULL_BIT there yields exactly one sample per CLKS_PER_BIT cycles.
  assign tick = (timer == 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= 16'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_par   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      frame_err <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      bad_par   <= bad_par_next;
`endif
    end
  end

  always_comb begin
    state_next     = state;
    timer_next     = (timer != 16'd0) ? timer - 16'd1 : 16'd0;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    frame_err_next = 1'b0;
    push           = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_par_next   = bad_par;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          timer_next = HALF_BIT;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_next   = DATA;
            timer_next   = FULL_BIT;
            bit_cnt_next = 3'd0;
`ifdef UART_RX_PARITY_EN
            bad_par_next = 1'b0;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_next   = {rx_s, shift[7:1]};
          timer_next   = FULL_BIT;
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          timer_next = FULL_BIT;
          if (rx_s != ^shift) begin
            bad_par_next   = 1'b1;
            frame_err_next = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            push       = ~bad_par;
`else
            push       = 1'b1;
`endif
          end else begin
            state_next     = BREAK;
            frame_err_next = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          pop, full, wr_en;

  assign pop   = rx_valid & rx_ready;
  assign full  = (count == LW'(FIFO_DEPTH));
  // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + LW'(1);
      else if (!wr_en && pop) count <= count - LW'(1);
      if (push && full && !pop) overrun <= 1'b1;
      else if (overrun_clr)     overrun <= 1'b0;
    end
  end

  assign rx_data    = mem[rd_ptr];
  assign rx_valid   = (count != '0);
  assign fifo_level = count;

endmodule

// File: tb/tb_tt_uart_rx.sv
// tb/tb_tt_uart_rx.sv - directed self-checking bench for tt_uart_rx (CLKS_PER_BIT=8, FIFO_DEPTH=4)
module tb_tt_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic       overrun;
  logic       overrun_clr;

  int tests    = 0;
  int failures = 0;
  int fe_count = 0;

  tt_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) tick();
  endtask

  // Start bit, data LSB first and (when enabled) the even parity bit; caller drives the stop bit.
  task automatic send_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_head(d);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (2) tick();
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    tests++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    tests++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    tests++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    tests++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_basic();
    fe_count = 0;
    send_head(8'hA5);
    rx = 1'b1;
    repeat (6) tick();
    tests++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", rx_valid); end
    tick();
    tests++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    tests++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    tests++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL basic_level: got %0d expected 1", fifo_level); end
    repeat (3) tick();
    pop_one();
    tests++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_pop_valid: got %b expected 0", rx_valid); end
    tests++; if (fe_count !== 0) begin failures++; $display("FAIL basic_frame_err: got %0d expected 0", fe_count); end
  endtask

  task automatic test_glitch();
    fe_count = 0;
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (20) tick();
    tests++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
    tests++; if (fe_count !== 0) begin failures++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_count); end
    send_byte(8'h5A);
    tests++; if (rx_data !== 8'h5A || fifo_level !== 3'd1) begin failures++; $display("FAIL glitch_next_byte: got %h/%0d expected 5a/1", rx_data, fifo_level); end
    pop_one();
  endtask

  task automatic test_frame_err();
    fe_count = 0;
    send_head(8'h3C);
    rx = 1'b0;
    repeat (CPB + 40) tick();
    rx = 1'b1;
    repeat (10) tick();
    tests++; if (fe_count !== 1) begin failures++; $display("FAIL ferr_pulses: got %0d expected 1", fe_count); end
    tests++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL ferr_discard: got %0d expected 0", fifo_level); end
    send_byte(8'h11);
    tests++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL ferr_next_level: got %0d expected 1", fifo_level); end
    tests++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ferr_next_data: got %h expected 11", rx_data); end
    tests++; if (fe_count !== 1) begin failures++; $display("FAIL ferr_pulses_after: got %0d expected 1", fe_count); end
    pop_one();
  endtask

  task automatic test_overrun();
    for (int v = 1; v <= 5; v++) send_byte(8'(v));
    tests++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovr_level: got %0d expected 4", fifo_level); end
    tests++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    tests++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    // Clear coincides with a fresh drop: the drop must win.
    send_head(8'h06);
    rx = 1'b1;
    repeat (6) tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    tests++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins: got %b expected 1", overrun); end
    repeat (3) tick();
    for (int v = 1; v <= 4; v++) begin
      tests++; if (rx_data !== 8'(v)) begin failures++; $display("FAIL ovr_pop_data: got %h expected %h", rx_data, 8'(v)); end
      pop_one();
    end
    tests++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL ovr_drained: got %0d expected 0", fifo_level); end
    tests++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    tests++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_final_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'h22, 8'h23, 8'h24, 8'h77};
    for (int v = 8'h21; v <= 8'h24; v++) send_byte(8'(v));
    tests++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_full: got %0d expected 4", fifo_level); end
    send_head(8'h77);
    rx = 1'b1;
    repeat (6) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tests++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fpp_level: got %0d expected 4", fifo_level); end
    tests++; if (rx_data !== 8'h22) begin failures++; $display("FAIL fpp_head: got %h expected 22", rx_data); end
    repeat (3) tick();
    tests++; if (overrun !== 1'b0) begin failures++; $display("FAIL fpp_overrun: got %b expected 0", overrun); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (rx_data !== exp_q[i]) begin failures++; $display("FAIL fpp_order: got %h expected %h", rx_data, exp_q[i]); end
      pop_one();
    end
    tests++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL fpp_empty: got %b expected 0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    fe_count = 0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    tick();
    tests++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_reset_level: got %0d expected 0", fifo_level); end
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (120) tick();
    tests++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_no_byte: got %b expected 0", rx_valid); end
    tests++; if (fe_count !== 0) begin failures++; $display("FAIL mid_frame_err: got %0d expected 0", fe_count); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    fe_count = 0;
    send_byte(8'h07);
    tests++; if (rx_data !== 8'h07 || fifo_level !== 3'd1) begin failures++; $display("FAIL par_good: got %h/%0d expected 07/1", rx_data, fifo_level); end
    pop_one();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    for (int i = 3; i < 8; i++) drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (2) tick();
    tests++; if (fe_count !== 1) begin failures++; $display("FAIL par_bad_err: got %0d expected 1", fe_count); end
    tests++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL par_bad_drop: got %0d expected 0", fifo_level); end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    rx          = 1'b1;
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    repeat (3) tick();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_push_pop();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
